// File: rtl/sram_bus_arbiter_if.sv
// Single-port sram bus: a transaction completes in the cycle en=1 and stall=0.
// The master side issues requests, and the slave side answers them.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WE_W   = 4
);
  logic              en;
  logic [WE_W-1:0]   we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_w;
  logic [DATA_W-1:0] data_r;
  logic              stall;

  modport master (output en, we, addr, data_w, input data_r, stall);
  modport slave  (input en, we, addr, data_w, output data_r, stall);
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one downstream sram port between the instruction and data buses.
// Data has priority. A bounded streak counter makes sure fetch is eventually served.
module sram_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WE_W         = 4,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_arbiter_if.slave  i_bus,
  sram_bus_arbiter_if.slave  d_bus,
  sram_bus_arbiter_if.master m_bus
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [STREAK_W-1:0] streak_inc;

  logic              sel_en;
  logic [WE_W-1:0]   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data_w;

  assign streak_inc = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;

  // Grant changes happen only from IDLE. The grant is released when the
  // transaction completes or when the owner withdraws its request.
  always_comb begin
    // NOTE: every comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      IDLE: begin
        if (d_bus.en && i_bus.en && streak_q == STREAK_MAX) begin
          state_d  = GNT_I;
          streak_d = '0;
        end else if (d_bus.en) begin
          state_d  = GNT_D;
          streak_d = i_bus.en ? streak_inc : '0;
        end else if (i_bus.en) begin
          state_d  = GNT_I;
          streak_d = '0;
        end
      end
      GNT_I: if (!i_bus.en || !m_bus.stall) state_d = IDLE;
      GNT_D: if (!d_bus.en || !m_bus.stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset overrides the registered state, so the port is quiet in the reset cycle.
  always_comb begin
    sel_en       = 1'b0;
    sel_we       = '0;
    sel_addr     = '0;
    sel_data_w   = '0;
    i_bus.stall  = i_bus.en;
    d_bus.stall  = d_bus.en;
    i_bus.data_r = '0;
    d_bus.data_r = '0;
    if (!rst) begin
      unique case (state_q)
        GNT_I: begin
          sel_en       = i_bus.en;
          sel_we       = i_bus.we;
          sel_addr     = i_bus.addr;
          sel_data_w   = i_bus.data_w;
          i_bus.stall  = m_bus.stall;
          i_bus.data_r = m_bus.data_r;
        end
        GNT_D: begin
          sel_en       = d_bus.en;
          sel_we       = d_bus.we;
          sel_addr     = d_bus.addr;
          sel_data_w   = d_bus.data_w;
          d_bus.stall  = m_bus.stall;
          d_bus.data_r = m_bus.data_r;
        end
        default: ;
      endcase
    end
  end

  assign m_bus.en     = sel_en;
  assign m_bus.we     = sel_we;
  assign m_bus.addr   = sel_addr;
  assign m_bus.data_w = sel_data_w;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  a_idle_quiet: assert property (@(posedge clk) (state_q == IDLE) |-> !m_bus.en);
  a_streak_max: assert property (@(posedge clk) streak_q <= STREAK_MAX);
  a_hold_i: assert property (@(posedge clk) disable iff (rst)
    (state_q == GNT_I && i_bus.en && m_bus.stall) |=> state_q == GNT_I);
  a_hold_d: assert property (@(posedge clk) disable iff (rst)
    (state_q == GNT_D && d_bus.en && m_bus.stall) |=> state_q == GNT_D);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter. Each directed test pushes the downstream
// transactions it expects. A monitor pops them as they complete on the port.
module tb_sram_bus_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int WE_W         = 4;
  localparam int MAX_D_STREAK = 4;
  localparam logic [31:0] RD_KEY = 32'hA5A5_5A5A;

  typedef struct {
    bit          is_d;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data_w;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W)) i_bus ();
  sram_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W)) d_bus ();
  sram_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W)) m_bus ();

  sram_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W), .MAX_D_STREAK(MAX_D_STREAK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .i_bus(i_bus),
    .d_bus(d_bus),
    .m_bus(m_bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   stall_cfg = 0;
  int   busy_cnt = 0;
  txn_t exp_q[$];
  txn_t mon_txn;

  // Downstream memory: stalls stall_cfg cycles per transaction, read data = addr ^ key.
  assign m_bus.stall  = m_bus.en && (busy_cnt < stall_cfg);
  assign m_bus.data_r = m_bus.addr ^ RD_KEY;
  always @(posedge clk) busy_cnt <= (m_bus.en && m_bus.stall) ? busy_cnt + 1 : 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_bus.en && !m_bus.stall) begin
      n_done <= n_done + 1;
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_txn = exp_q.pop_front();
        check("sb_addr", m_bus.addr, mon_txn.addr);
        check("sb_we", m_bus.we, mon_txn.we);
        check("sb_data_w", m_bus.data_w, mon_txn.data_w);
        if (mon_txn.is_d) begin
          check("sb_d_stall", d_bus.stall, 1'b0);
          check("sb_d_data_r", d_bus.data_r, mon_txn.addr ^ RD_KEY);
          check("sb_i_stall_other", i_bus.stall, i_bus.en);
          check("sb_i_data_r_other", i_bus.data_r, 32'h0);
        end else begin
          check("sb_i_stall", i_bus.stall, 1'b0);
          check("sb_i_data_r", i_bus.data_r, mon_txn.addr ^ RD_KEY);
          check("sb_d_stall_other", d_bus.stall, d_bus.en);
          check("sb_d_data_r_other", d_bus.data_r, 32'h0);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] data_w, input int n);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.data_w = data_w;
    for (int k = 0; k < n; k++) exp_q.push_back(t);
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (n_done < target && k < 200);
    check(tag, n_done, target);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    stall_cfg = 0;
    i_bus.en = 1'b1; i_bus.we = '0; i_bus.addr = 32'h0; i_bus.data_w = '0;
    d_bus.en = 1'b1; d_bus.we = '0; d_bus.addr = 32'h0; d_bus.data_w = '0;

    // Reset: port quiet, stalls follow request enables.
    @(negedge clk);
    check("rst_m_en", m_bus.en, 1'b0);
    check("rst_i_stall", i_bus.stall, 1'b1);
    check("rst_d_stall", d_bus.stall, 1'b1);
    check("rst_d_data_r", d_bus.data_r, 32'h0);
    sync();
    i_bus.en = 1'b0; d_bus.en = 1'b0;
    sync();
    rst = 1'b0;

    // T1: lone fetch, two downstream stall cycles.
    stall_cfg = 2;
    push(1'b0, 4'h0, 32'h1FC0_0000, 32'h0, 1);
    i_bus.en = 1'b1; i_bus.addr = 32'h1FC0_0000;
    @(negedge clk);
    check("t1_c0_m_en", m_bus.en, 1'b0);
    check("t1_c0_i_stall", i_bus.stall, 1'b1);
    @(negedge clk);
    check("t1_c1_m_en", m_bus.en, 1'b1);
    check("t1_c1_m_addr", m_bus.addr, 32'h1FC0_0000);
    check("t1_c1_i_stall", i_bus.stall, 1'b1);
    @(negedge clk);
    check("t1_c2_i_stall", i_bus.stall, 1'b1);
    @(negedge clk);
    check("t1_c3_i_stall", i_bus.stall, 1'b0);
    sync();
    i_bus.en = 1'b0;
    @(negedge clk);
    check("t1_c4_m_en", m_bus.en, 1'b0);
    check("t1_drain", exp_q.size(), 0);
    sync();

    // T6: data write passes through untouched.
    stall_cfg = 0;
    push(1'b1, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, 1);
    i_bus.addr = 32'h0000_2000;
    d_bus.en = 1'b1; d_bus.we = 4'b0011; d_bus.addr = 32'h0000_1004; d_bus.data_w = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t6_c0_m_en", m_bus.en, 1'b0);
    check("t6_c0_d_stall", d_bus.stall, 1'b1);
    @(negedge clk);
    check("t6_m_en", m_bus.en, 1'b1);
    check("t6_m_we", m_bus.we, 4'b0011);
    check("t6_m_addr", m_bus.addr, 32'h0000_1004);
    check("t6_m_data_w", m_bus.data_w, 32'hDEAD_BEEF);
    check("t6_i_data_r", i_bus.data_r, 32'h0);
    sync();
    d_bus.en = 1'b0; d_bus.we = '0; d_bus.data_w = '0;
    @(negedge clk);
    check("t6_idle_m_en", m_bus.en, 1'b0);
    check("t6_drain", exp_q.size(), 0);
    sync();

    // T3: both held, zero-wait memory -> D,D,D,D,I.
    base = n_done;
    push(1'b1, 4'h0, 32'h0000_5000, 32'h0, MAX_D_STREAK);
    push(1'b0, 4'h0, 32'h0000_6000, 32'h0, 1);
    d_bus.en = 1'b1; d_bus.addr = 32'h0000_5000;
    i_bus.en = 1'b1; i_bus.addr = 32'h0000_6000;
    wait_done(base + MAX_D_STREAK + 1, "t3_done");
    d_bus.en = 1'b0; i_bus.en = 1'b0;
    check("t3_drain", exp_q.size(), 0);

    // T2: contention from a cleared streak -> data first, then fetch.
    stall_cfg = 1;
    push(1'b1, 4'h0, 32'h0000_3000, 32'h0, 1);
    push(1'b0, 4'h0, 32'h0000_4000, 32'h0, 1);
    d_bus.en = 1'b1; d_bus.addr = 32'h0000_3000;
    i_bus.en = 1'b1; i_bus.addr = 32'h0000_4000;
    @(negedge clk);
    check("t2_c0_m_en", m_bus.en, 1'b0);
    @(negedge clk);
    check("t2_c1_m_addr", m_bus.addr, 32'h0000_3000);
    check("t2_c1_i_stall", i_bus.stall, 1'b1);
    @(negedge clk);
    check("t2_c2_i_stall", i_bus.stall, 1'b1);
    sync();
    d_bus.en = 1'b0;
    @(negedge clk);
    check("t2_c3_m_en", m_bus.en, 1'b0);
    check("t2_c3_i_stall", i_bus.stall, 1'b1);
    @(negedge clk);
    check("t2_c4_m_addr", m_bus.addr, 32'h0000_4000);
    @(negedge clk);
    check("t2_c5_i_stall", i_bus.stall, 1'b0);
    sync();
    i_bus.en = 1'b0;
    @(negedge clk);
    check("t2_drain", exp_q.size(), 0);
    sync();

    // T4: data withdraws while stalled; no completion, grant released.
    stall_cfg = 100;
    d_bus.en = 1'b1; d_bus.addr = 32'h0000_7000;
    @(negedge clk);
    @(negedge clk);
    check("t4_c1_m_en", m_bus.en, 1'b1);
    check("t4_c1_d_stall", d_bus.stall, 1'b1);
    sync();
    d_bus.en = 1'b0;
    @(negedge clk);
    check("t4_c2_m_en", m_bus.en, 1'b0);
    sync();
    stall_cfg = 0;
    push(1'b0, 4'h0, 32'h0000_8000, 32'h0, 1);
    i_bus.en = 1'b1; i_bus.addr = 32'h0000_8000;
    @(negedge clk);
    check("t4_c3_m_en", m_bus.en, 1'b0);
    @(negedge clk);
    check("t4_c4_m_en", m_bus.en, 1'b1);
    check("t4_c4_m_addr", m_bus.addr, 32'h0000_8000);
    sync();
    i_bus.en = 1'b0;
    check("t4_drain", exp_q.size(), 0);

    // T5: reset during a stalled fetch grant.
    stall_cfg = 100;
    i_bus.en = 1'b1; i_bus.addr = 32'h0000_9000;
    @(negedge clk);
    @(negedge clk);
    check("t5_c1_m_en", m_bus.en, 1'b1);
    sync();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_m_en", m_bus.en, 1'b0);
    check("t5_rst_i_stall", i_bus.stall, 1'b1);
    check("t5_rst_d_stall", d_bus.stall, 1'b0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle_m_en", m_bus.en, 1'b0);
    check("t5_idle_i_stall", i_bus.stall, 1'b1);
    sync();
    push(1'b0, 4'h0, 32'h0000_9000, 32'h0, 1);
    stall_cfg = 0;
    @(negedge clk);
    check("t5_regrant_m_en", m_bus.en, 1'b1);
    sync();
    i_bus.en = 1'b0;
    check("t5_drain", exp_q.size(), 0);

    // T7: reset clears a partial streak -> a full D,D,D,D,I run follows.
    base = n_done;
    push(1'b1, 4'h0, 32'h0000_B000, 32'h0, 2);
    d_bus.en = 1'b1; d_bus.addr = 32'h0000_B000;
    i_bus.en = 1'b1; i_bus.addr = 32'h0000_C000;
    wait_done(base + 2, "t7_pre_done");
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_m_en", m_bus.en, 1'b0);
    check("t7_rst_d_stall", d_bus.stall, 1'b1);
    sync();
    rst = 1'b0;
    push(1'b1, 4'h0, 32'h0000_B000, 32'h0, MAX_D_STREAK);
    push(1'b0, 4'h0, 32'h0000_C000, 32'h0, 1);
    wait_done(base + 2 + MAX_D_STREAK + 1, "t7_done");
    d_bus.en = 1'b0; i_bus.en = 1'b0;
    check("t7_drain", exp_q.size(), 0);

    repeat (3) sync();
    check("final_no_extra", n_done, base + 2 + MAX_D_STREAK + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
